rect_plotter: RTL and testbench
===============================

# rect_plotter

Rectangle rasteriser that writes into the 160x120 VGA framebuffer, the write-side counterpart to the star-search image reader. On a start pulse it latches a bounding box and colour, then walks the box one pixel per clock, presenting x, y, colour, plot and a linear framebuffer address. In outline mode it draws the box border around a found star; in fill mode it paints the whole box, which is used to clean a region to black.

## Interface
- X_W, 8: x coordinate width.
- Y_W, 7: y coordinate width.
- X_MAX, 159: last valid column.
- Y_MAX, 119: last valid row.
- COLOUR_W, 3: colour width (1 bit per channel).
- clk  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous active-low reset.
- start  in  1  request pulse; accepted only in IDLE.
- fill  in  1  0 = outline only, 1 = solid fill; sampled with start.
- x0, x1  in  X_W  box column corners, any order.
- y0, y1  in  Y_W  box row corners, any order.
- colour_in  in  COLOUR_W  draw colour; sampled with start.
- abort  in  1  stop the current job at the next clock edge.
- x  out  X_W  current pixel column.
- y  out  Y_W  current pixel row.
- colour  out  COLOUR_W  latched colour.
- plot  out  1  write strobe for (x, y, colour).
- addr  out  15  y*160 + x, aligned with plot.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE
  - busy = 0.
  - On start: latch xl = min(x0,x1), xr = max(x0,x1), yt = min(y0,y1), yb = max(y0,y1).
  - Clamp each latched value to X_MAX / Y_MAX.
  - Latch fill and colour_in.
  - Load x = xl, y = yt, then go to SCAN.
- SCAN
  - Raster order: x increments each cycle; when x == xr, x returns to xl and y increments.
  - At x == xr and y == yb, go to DONE.
  - plot = 1 on every SCAN cycle when fill = 1.
  - When fill = 0, plot = 1 only when x == xl, x == xr, y == yt or y == yb. Interior cycles still advance but do not plot.
- DONE
  - Pulse done for one cycle.
  - Return to IDLE.
- abort in SCAN: go to DONE at the next edge. No further plot after that edge; done still pulses.
- start while busy is ignored and not queued.
- Degenerate boxes:
  - xl == xr or yt == yb gives a line.
  - A single point gives one plot cycle.
  - Outline of a 1-wide box plots every pixel.
- Arithmetic:
  - Counters are X_W / Y_W unsigned.
  - Comparisons are unsigned.
  - addr is computed zero-extended, without truncation before the final 15 bits.

## Timing
- Reset values: x = 0, y = 0, colour = 0, plot = 0, addr = 0, busy = 0, done = 0, state IDLE.
- start sampled at edge N → first pixel (xl, yt) presented with plot during cycle N+1; busy high from N+1.
- Throughput: one pixel per clock. A w×h box occupies exactly w*h SCAN cycles.
- done is high in cycle N+1+w*h; busy is low in that same cycle.
- A new start is accepted in the cycle after done (IDLE).
- x, y, colour, addr and plot are registered and change together. The consumer samples all of them on the edge where plot = 1.
- resetn low at any time, mid-SCAN included:
  - Immediate return to reset values.
  - No done pulse.
  - The partially drawn box is left as is.

## Structure
- Shared package `rect_plot_pkg`:
  - State encoding (IDLE, SCAN, DONE).
  - SCREEN_W = 160 and SCREEN_H = 120.
  - Default X_W, Y_W and COLOUR_W.
- Sub-module: instantiate the existing `vga_address_translator` with RESOLUTION "160x120" for addr. Feed it the registered x and y so addr stays aligned with plot.
- The FSM and the two counters stay in the top module. No further hierarchy.

## Test plan
- Fill 2×2:
  - Stimulus: start, fill = 1, x0 = 10, x1 = 11, y0 = 5, y1 = 6, colour = 3'b100.
  - Response: plots (10,5), (11,5), (10,6), (11,6) on consecutive cycles with addr 810, 811, 970, 971. done on cycle 5 after start.
- Outline 4×3:
  - Stimulus: fill = 0, x0 = 20, x1 = 23, y0 = 40, y1 = 42.
  - Response: 12 SCAN cycles and 10 plots; (21,41) and (22,41) are not plotted.
- Swapped and clamped corners:
  - Stimulus: x0 = 200, x1 = 158, y0 = 119, y1 = 119.
  - Response: xl = 158, xr = 159; plots (158,119) and (159,119) with addr 19198 and 19199.
- Busy and abort:
  - Stimulus: a second start two cycles into a 10×10 fill, then abort on cycle 5.
  - Response: the second start is ignored; exactly 5 plots; done pulses one cycle after the abort edge.
- Reset mid-operation:
  - Stimulus: resetn low during SCAN of a 5×5 box.
  - Response: plot, busy and done all 0 immediately. After release, a new 1×1 start at (0,0) gives a single plot with addr 0.

Source files
------------

// File: rtl/rect_plot_pkg.sv
// -----------------------------------------------------------------------------
// rect_plot_pkg
// Shared definitions for the rectangle rasteriser: FSM state encoding,
// framebuffer geometry and default coordinate/colour widths.
// -----------------------------------------------------------------------------
package rect_plot_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Framebuffer geometry
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // Default port widths
    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COLOUR_W = 3;

endpackage

// File: rtl/vga_address_translator.sv
// -----------------------------------------------------------------------------
// vga_address_translator
// Converts a pixel coordinate into a linear framebuffer address
// (y * width + x). Purely combinational; the address is formed at full
// output width so no partial product is truncated.
// Ports:
//   x           in   pixel column
//   y           in   pixel row
//   mem_address out  linear framebuffer address
// -----------------------------------------------------------------------------
module vga_address_translator #(
    parameter RESOLUTION = "160x120"
) (
    input  logic [((RESOLUTION == "320x240") ? 8 : 7):0]  x,
    input  logic [((RESOLUTION == "320x240") ? 7 : 6):0]  y,
    output logic [((RESOLUTION == "320x240") ? 16 : 14):0] mem_address
);

    localparam int AW = (RESOLUTION == "320x240") ? 17 : 15;

    logic [AW-1:0] w_x_ext;
    logic [AW-1:0] w_y_ext;

    assign w_x_ext = AW'(x);
    assign w_y_ext = AW'(y);

    // y*width built from shifts: 320 = 256 + 64, 160 = 128 + 32
    generate
        if (RESOLUTION == "320x240") begin : g_320
            assign mem_address = (w_y_ext << 8) + (w_y_ext << 6) + w_x_ext;
        end else begin : g_160
            assign mem_address = (w_y_ext << 7) + (w_y_ext << 5) + w_x_ext;
        end
    endgenerate

endmodule

// File: rtl/rect_plotter.sv
// -----------------------------------------------------------------------------
// rect_plotter
// Rasterises an axis-aligned rectangle into the 160x120 framebuffer, one pixel
// per clock in raster order. Outline mode plots only border pixels (interior
// cycles still advance); fill mode plots every pixel.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   start              job request, accepted only when idle
//   fill               0 = outline, 1 = solid (sampled with start)
//   x0, x1, y0, y1     box corners in any order (clamped to the screen)
//   colour_in          draw colour (sampled with start)
//   abort              ends the current scan at the next edge
//   x, y, colour       current pixel and latched colour
//   plot               write strobe for x/y/colour/addr
//   addr               y*160 + x, aligned with plot
//   busy               high while scanning
//   done               one-cycle completion pulse
// -----------------------------------------------------------------------------
module rect_plotter
    import rect_plot_pkg::*;
#(
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int X_MAX    = SCREEN_W - 1,
    parameter int Y_MAX    = SCREEN_H - 1,
    parameter int COLOUR_W = DEF_COLOUR_W
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic                fill,
    input  logic [X_W-1:0]      x0,
    input  logic [X_W-1:0]      x1,
    input  logic [Y_W-1:0]      y0,
    input  logic [Y_W-1:0]      y1,
    input  logic [COLOUR_W-1:0] colour_in,
    input  logic                abort,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic [14:0]         addr,
    output logic                busy,
    output logic                done
);

    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

    logic [1:0]          r_state;
    logic [X_W-1:0]      r_x, r_xl, r_xr;
    logic [Y_W-1:0]      r_y, r_yt, r_yb;
    logic [COLOUR_W-1:0] r_colour;
    logic                r_fill;
    logic                r_plot;

    logic [X_W-1:0]      w_xl, w_xr, w_x_nxt;
    logic [Y_W-1:0]      w_yt, w_yb, w_y_nxt;
    logic                w_eol;
    logic                w_last;
    logic                w_edge_nxt;
    logic [14:0]         w_addr;

    // Ordered and clamped corners for a new job
    always_comb begin
        w_xl = (x0 < x1) ? x0 : x1;
        w_xr = (x0 < x1) ? x1 : x0;
        w_yt = (y0 < y1) ? y0 : y1;
        w_yb = (y0 < y1) ? y1 : y0;
        if (w_xl > X_LIM) begin
            w_xl = X_LIM;
        end else begin
            w_xl = w_xl;
        end
        if (w_xr > X_LIM) begin
            w_xr = X_LIM;
        end else begin
            w_xr = w_xr;
        end
        if (w_yt > Y_LIM) begin
            w_yt = Y_LIM;
        end else begin
            w_yt = w_yt;
        end
        if (w_yb > Y_LIM) begin
            w_yb = Y_LIM;
        end else begin
            w_yb = w_yb;
        end
    end

    // Raster step and border test for the pixel following the current one
    always_comb begin
        w_eol  = (r_x == r_xr);
        w_last = w_eol && (r_y == r_yb);
        if (w_eol) begin
            w_x_nxt = r_xl;
            w_y_nxt = r_y + 1'b1;
        end else begin
            w_x_nxt = r_x + 1'b1;
            w_y_nxt = r_y;
        end
        w_edge_nxt = (w_x_nxt == r_xl) || (w_x_nxt == r_xr) ||
                     (w_y_nxt == r_yt) || (w_y_nxt == r_yb);
    end

    // FSM, scan counters and registered pixel outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= ST_IDLE;
            r_x      <= '0;
            r_y      <= '0;
            r_xl     <= '0;
            r_xr     <= '0;
            r_yt     <= '0;
            r_yb     <= '0;
            r_colour <= '0;
            r_fill   <= 1'b0;
            r_plot   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_xl     <= w_xl;
                        r_xr     <= w_xr;
                        r_yt     <= w_yt;
                        r_yb     <= w_yb;
                        r_x      <= w_xl;
                        r_y      <= w_yt;
                        r_fill   <= fill;
                        r_colour <= colour_in;
                        // The top-left corner is always on the border
                        r_plot   <= 1'b1;
                        r_state  <= ST_SCAN;
                    end else begin
                        r_plot   <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (abort || w_last) begin
                        r_plot  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_x     <= w_x_nxt;
                        r_y     <= w_y_nxt;
                        r_plot  <= r_fill || w_edge_nxt;
                    end
                end
                ST_DONE: begin
                    r_plot  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_plot  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Address taken from the registered coordinates so it moves with plot
    vga_address_translator #(
        .RESOLUTION ("160x120")
    ) u_addr (
        .x           (r_x),
        .y           (r_y),
        .mem_address (w_addr)
    );

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign addr   = w_addr;
    assign busy   = (r_state == ST_SCAN);
    assign done   = (r_state == ST_DONE);

endmodule

// File: tb/tb_rect_plotter.sv
module tb_rect_plotter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        fill;
    logic [7:0]  x0, x1, x;
    logic [6:0]  y0, y1, y;
    logic [2:0]  colour_in, colour;
    logic        abort;
    logic        plot;
    logic [14:0] addr;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int px;
        int py;
        bit pp;
    } pix_t;

    always #5 clk = ~clk;

    rect_plotter dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .fill      (fill),
        .x0        (x0),
        .x1        (x1),
        .y0        (y0),
        .y1        (y1),
        .colour_in (colour_in),
        .abort     (abort),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .addr      (addr),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one job from the cycle after an edge; abort_at > 0 aborts after that
    // many scan cycles, restart_at >= 0 fires a second start at that scan index.
    task automatic run_job(input int ax0, input int ax1, input int ay0, input int ay1,
                           input bit afill, input int acol, input int abort_at,
                           input int restart_at);
        int   xl, xr, yt, yb;
        int   plots;
        int   exp_plots;
        pix_t q[$];
        pix_t p;
        xl = (ax0 < ax1) ? ax0 : ax1;
        xr = (ax0 < ax1) ? ax1 : ax0;
        yt = (ay0 < ay1) ? ay0 : ay1;
        yb = (ay0 < ay1) ? ay1 : ay0;
        if (xl > 159) xl = 159;
        if (xr > 159) xr = 159;
        if (yt > 119) yt = 119;
        if (yb > 119) yb = 119;
        for (int yy = yt; yy <= yb; yy++) begin
            for (int xx = xl; xx <= xr; xx++) begin
                p.px = xx;
                p.py = yy;
                p.pp = afill || xx == xl || xx == xr || yy == yt || yy == yb;
                if (abort_at == 0 || q.size() < abort_at) q.push_back(p);
            end
        end
        plots     = 0;
        exp_plots = 0;
        x0        = ax0[7:0];
        x1        = ax1[7:0];
        y0        = ay0[6:0];
        y1        = ay1[6:0];
        fill      = afill;
        colour_in = acol[2:0];
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < q.size(); n++) begin
            chk("x", x, q[n].px);
            chk("y", y, q[n].py);
            chk("addr", addr, q[n].py * 160 + q[n].px);
            chk("plot", plot, q[n].pp);
            chk("busy", busy, 1);
            chk("done_scan", done, 0);
            chk("colour", colour, acol);
            if (plot === 1'b1) plots++;
            if (q[n].pp) exp_plots++;
            if (abort_at == n + 1) abort = 1'b1;
            if (restart_at == n) begin
                start     = 1'b1;
                x0        = 8'd0;
                x1        = 8'd3;
                y0        = 7'd0;
                y1        = 7'd3;
                fill      = ~afill;
                colour_in = ~colour_in;
            end
            @(posedge clk); #1;
            abort = 1'b0;
            start = 1'b0;
        end
        chk("plot_count", plots, exp_plots);
        chk("done_pulse", done, 1);
        chk("busy_at_done", busy, 0);
        chk("plot_at_done", plot, 0);
        @(posedge clk); #1;
        chk("done_clear", done, 0);
        chk("busy_idle", busy, 0);
        chk("plot_idle", plot, 0);
    endtask

    initial begin
        int rx0, rx1, ry0, ry1;
        resetn    = 1'b0;
        start     = 1'b0;
        fill      = 1'b0;
        abort     = 1'b0;
        x0        = 8'd0;
        x1        = 8'd0;
        y0        = 7'd0;
        y1        = 7'd0;
        colour_in = 3'd0;
        #12;
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_addr", addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_job(10, 11, 5, 6, 1'b1, 4, 0, -1);
        run_job(20, 23, 40, 42, 1'b0, 2, 0, -1);
        run_job(200, 158, 119, 119, 1'b0, 7, 0, -1);
        run_job(30, 39, 60, 69, 1'b1, 5, 5, 1);
        run_job(50, 50, 50, 50, 1'b0, 1, 0, -1);
        run_job(70, 70, 10, 14, 1'b0, 6, 0, -1);

        // Randomised small boxes, including off-screen corners
        for (int k = 0; k < 10; k++) begin
            rx0 = int'($urandom_range(0, 255));
            rx1 = rx0 + int'($urandom_range(0, 12)) - 6;
            if (rx1 < 0) rx1 = 0;
            if (rx1 > 255) rx1 = 255;
            ry0 = int'($urandom_range(0, 127));
            ry1 = ry0 + int'($urandom_range(0, 10)) - 5;
            if (ry1 < 0) ry1 = 0;
            if (ry1 > 127) ry1 = 127;
            run_job(rx0, rx1, ry0, ry1, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 7)), 0, -1);
        end

        // Reset in the middle of a 5x5 scan
        x0        = 8'd30;
        x1        = 8'd34;
        y0        = 7'd50;
        y1        = 7'd54;
        fill      = 1'b1;
        colour_in = 3'd6;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_busy", busy, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mr_plot", plot, 0);
        chk("mr_busy", busy, 0);
        chk("mr_done", done, 0);
        chk("mr_x", x, 0);
        chk("mr_addr", addr, 0);
        chk("mr_colour", colour, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("mr_idle_done", done, 0);
        run_job(0, 0, 0, 0, 1'b1, 5, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
